// File: rtl/imem_dmem_arbiter_if.sv
// Purpose: bundle of the fetch, data and memory-side signals of the imem/dmem arbiter.
// Latency: none, wires only.
// Backpressure: req held until ack on the requester side; mem_stall/mem_done on the memory side.
interface imem_dmem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_flush;
    logic          i_ack;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_wr;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_stall;
    logic          mem_done;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          err;

    // Arbiter side
    modport slave (
        input  i_req, i_addr, i_flush, d_req, d_wr, d_addr, d_wdata,
        input  mem_stall, mem_done, mem_rdata,
        output i_ack, i_rdata, d_ack, d_rdata,
        output mem_en, mem_wr, mem_addr, mem_wdata, busy, err
    );

    // Pipeline stages plus memory side
    modport master (
        output i_req, i_addr, i_flush, d_req, d_wr, d_addr, d_wdata,
        output mem_stall, mem_done, mem_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata,
        input  mem_en, mem_wr, mem_addr, mem_wdata, busy, err
    );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Purpose: arbitrates one single-port stalling memory between fetch (I) and data (D) requesters.
// Latency: req seen in IDLE at cycle 0, mem_en at 1, ack at 3 at best; +1 per stall or wait cycle.
// Backpressure: requests held until ack; mem_stall keeps mem_en asserted, TIMEOUT bounds a hung access.
module imem_dmem_arbiter #(
    parameter int AW           = 16,
    parameter int DW           = 16,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 15
) (
    input  logic              clk,
    input  logic              rst,
    imem_dmem_arbiter_if.slave bus
);
    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
    localparam logic [TW-1:0] TCNT_MAX   = TW'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, ISSUE_I, ISSUE_D, WAIT_I, WAIT_D, DROP} state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] streak, streak_nxt;
    logic [TW-1:0] tcnt, tcnt_nxt;
    logic          wr_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q, i_rdata_q, d_rdata_q;
    logic          i_ack_q, d_ack_q, err_q;
    logic          i_pend, d_pend, turnaround, gnt_i, gnt_d;
    logic          i_ack_nxt, d_ack_nxt, err_nxt, i_cap, d_cap;

    // Grant decision and starvation streak. No grant in an ack cycle: the
    // arbiter takes one turnaround cycle after each completion, so a
    // requester re-raising its request competes fairly on the next cycle.
    always_comb begin
        i_pend     = bus.i_req && !i_ack_q && !bus.i_flush;
        d_pend     = bus.d_req && !d_ack_q;
        turnaround = i_ack_q || d_ack_q;
        gnt_d      = (state == IDLE) && !turnaround && d_pend &&
                     (!i_pend || (streak != STREAK_MAX));
        gnt_i      = (state == IDLE) && !turnaround && i_pend && !gnt_d;
        streak_nxt = streak;
        if (state == IDLE) begin
            if (gnt_i) begin
                streak_nxt = '0;
            end else if (gnt_d && i_pend) begin
                if (streak != STREAK_MAX) streak_nxt = streak + 1'b1;
            end else if (!bus.i_req) begin
                streak_nxt = '0;
            end
        end
    end

    // Access sequencing: issue with stall retry, wait with timeout, flush handling.
    always_comb begin
        state_nxt = state;
        tcnt_nxt  = tcnt;
        i_ack_nxt = 1'b0;
        d_ack_nxt = 1'b0;
        err_nxt   = 1'b0;
        i_cap     = 1'b0;
        d_cap     = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_d)      state_nxt = ISSUE_D;
                else if (gnt_i) state_nxt = ISSUE_I;
            end
            ISSUE_I: begin
                tcnt_nxt = '0;
                // A flushed fetch the memory already accepted must still be
                // drained, otherwise a second access could overlap it.
                if (bus.i_flush)          state_nxt = bus.mem_stall ? IDLE : DROP;
                else if (!bus.mem_stall)  state_nxt = WAIT_I;
            end
            ISSUE_D: begin
                tcnt_nxt = '0;
                if (!bus.mem_stall) state_nxt = WAIT_D;
            end
            WAIT_I: begin
                if (bus.mem_done) begin
                    state_nxt = IDLE;
                    i_ack_nxt = !bus.i_flush;
                    i_cap     = !bus.i_flush;
                end else if (tcnt == TCNT_MAX) begin
                    state_nxt = IDLE;
                    i_ack_nxt = !bus.i_flush;
                    err_nxt   = !bus.i_flush;
                end else begin
                    tcnt_nxt = tcnt + 1'b1;
                    if (bus.i_flush) state_nxt = DROP;
                end
            end
            WAIT_D: begin
                if (bus.mem_done) begin
                    state_nxt = IDLE;
                    d_ack_nxt = 1'b1;
                    d_cap     = !wr_q;
                end else if (tcnt == TCNT_MAX) begin
                    state_nxt = IDLE;
                    d_ack_nxt = 1'b1;
                    err_nxt   = 1'b1;
                end else begin
                    tcnt_nxt = tcnt + 1'b1;
                end
            end
            DROP: begin
                if (bus.mem_done || (tcnt == TCNT_MAX)) state_nxt = IDLE;
                else                                    tcnt_nxt  = tcnt + 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, counters, latched request and registered responses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            streak    <= '0;
            tcnt      <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state   <= state_nxt;
            streak  <= streak_nxt;
            tcnt    <= tcnt_nxt;
            i_ack_q <= i_ack_nxt;
            d_ack_q <= d_ack_nxt;
            err_q   <= err_nxt;
            if (gnt_d) begin
                addr_q  <= bus.d_addr;
                wr_q    <= bus.d_wr;
                wdata_q <= bus.d_wdata;
            end else if (gnt_i) begin
                addr_q  <= bus.i_addr;
                wr_q    <= 1'b0;
            end
            if (i_cap) i_rdata_q <= bus.mem_rdata;
            if (d_cap) d_rdata_q <= bus.mem_rdata;
        end
    end

    assign bus.mem_en    = (state == ISSUE_I) || (state == ISSUE_D);
    assign bus.mem_wr    = (state == ISSUE_D) && wr_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.i_ack     = i_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.err       = err_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Purpose: scoreboard bench for imem_dmem_arbiter with requester drivers and a stalling memory model.
// Latency: expected ack cycles are hand-computed per directed vector.
// Backpressure: memory model applies programmable stall, done delay or no done at all.
module tb_imem_dmem_arbiter;
    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    imem_dmem_arbiter_if #(.AW(16), .DW(16)) bus ();

    imem_dmem_arbiter #(.AW(16), .DW(16), .MAX_D_STREAK(4), .TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          is_d;
        logic [15:0] rdata;
        bit          err;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    task automatic expect_ack(input bit is_d, input logic [15:0] rd, input bit e, input int c);
        exp_t x;
        x.is_d = is_d; x.rdata = rd; x.err = e; x.cyc = c;
        sb.push_back(x);
    endtask

    // Monitor: every ack pops one expectation.
    always @(negedge clk) begin
        if (bus.i_ack || bus.d_ack || bus.err) begin
            check("ack_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t x;
                x = sb.pop_front();
                check("ack_kind", {bus.d_ack, bus.i_ack}, x.is_d ? 32'd2 : 32'd1);
                check("ack_rdata", x.is_d ? bus.d_rdata : bus.i_rdata, x.rdata);
                check("ack_err", bus.err, x.err);
                check("ack_cycle", cyc, x.cyc);
            end
        end
    end

    // ---------------- requester drivers ----------------
    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } dreq_t;
    logic [15:0] i_q[$];
    dreq_t       d_q[$];

    // Hold each request until its ack, then present the next one straight away.
    always @(negedge clk) begin
        if (bus.i_ack && i_q.size() > 0) i_q.delete(0);
        if (bus.d_ack && d_q.size() > 0) d_q.delete(0);
        bus.i_req   = (i_q.size() > 0);
        bus.i_addr  = (i_q.size() > 0) ? i_q[0] : 16'h0;
        bus.d_req   = (d_q.size() > 0);
        bus.d_wr    = (d_q.size() > 0) ? d_q[0].wr : 1'b0;
        bus.d_addr  = (d_q.size() > 0) ? d_q[0].addr : 16'h0;
        bus.d_wdata = (d_q.size() > 0) ? d_q[0].wdata : 16'h0;
    end

    // ---------------- memory model ----------------
    logic [15:0] mem_arr [logic [15:0]];
    logic [15:0] acc_addr;
    int pend = 0;
    bit outstanding = 0;
    int cfg_delay = 1;
    int stall_left = 0;
    bit no_done = 0;
    int en_cycles = 0;
    int wr_cycles = 0;
    int wr_count = 0;

    function automatic logic [15:0] rd(input logic [15:0] a);
        return mem_arr.exists(a) ? mem_arr[a] : 16'hDEAD;
    endfunction

    always @(negedge clk) begin
        bus.mem_done = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                bus.mem_done  = 1'b1;
                bus.mem_rdata = rd(acc_addr);
                outstanding   = 0;
            end
        end
        bus.mem_stall = 1'b0;
        if (bus.mem_en) begin
            en_cycles++;
            if (bus.mem_wr) wr_cycles++;
            check("one_outstanding", 32'(outstanding), 32'd0);
            if (stall_left > 0) begin
                bus.mem_stall = 1'b1;
                stall_left--;
            end else begin
                acc_addr = bus.mem_addr;
                if (bus.mem_wr) begin
                    mem_arr[bus.mem_addr] = bus.mem_wdata;
                    wr_count++;
                end
                if (!no_done) begin
                    pend = cfg_delay;
                    outstanding = 1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) next_cycle();
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            next_cycle();
            n++;
        end
        check("drain_in_time", sb.size(), 0);
        repeat (3) next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- directed vectors ----------------
    initial begin
        int t0;
        rst = 1'b0;
        bus.i_flush = 1'b0;
        bus.mem_rdata = 16'h0;
        mem_arr[16'h0010] = 16'h0800;
        mem_arr[16'h0020] = 16'h0C00;
        mem_arr[16'h0030] = 16'h0D00;
        mem_arr[16'h0040] = 16'h1234;
        mem_arr[16'h0050] = 16'hABCD;
        mem_arr[16'h0070] = 16'h7777;
        mem_arr[16'h0200] = 16'h4444;
        for (int k = 0; k < 5; k++) mem_arr[16'h0210 + 16'(k)] = 16'h5000 + 16'(k);

        // Reset state
        next_cycle();
        check("rst_busy", bus.busy, 0);
        check("rst_strobes", {bus.mem_en, bus.mem_wr, bus.i_ack, bus.d_ack, bus.err}, 0);
        check("rst_data", {bus.i_rdata, bus.d_rdata}, 0);
        check("rst_mem_regs", {bus.mem_addr, bus.mem_wdata}, 0);
        next_cycle();
        rst = 1'b1;
        repeat (2) next_cycle();

        // Lone fetch
        t0 = cyc;
        i_q.push_back(16'h0010);
        expect_ack(0, 16'h0800, 0, t0 + 3);
        wait_to(t0 + 1);
        check("fetch_mem_en", bus.mem_en, 1);
        check("fetch_mem_wr", bus.mem_wr, 0);
        check("fetch_mem_addr", bus.mem_addr, 16'h0010);
        wait_drain(40);

        // Concurrent I and D: D first, I in the IDLE cycle after d_ack
        t0 = cyc;
        i_q.push_back(16'h0020);
        d_q.push_back('{1'b0, 16'h0200, 16'h0000});
        expect_ack(1, 16'h4444, 0, t0 + 3);
        expect_ack(0, 16'h0C00, 0, t0 + 7);
        wait_to(t0 + 1);
        check("conc_first_addr", bus.mem_addr, 16'h0200);
        wait_to(t0 + 5);
        check("conc_second_addr", bus.mem_addr, 16'h0020);
        wait_drain(40);

        // D streak: 4 D, forced I, then D again
        t0 = cyc;
        i_q.push_back(16'h0030);
        for (int k = 0; k < 5; k++) d_q.push_back('{1'b0, 16'h0210 + 16'(k), 16'h0000});
        for (int k = 0; k < 4; k++) expect_ack(1, 16'h5000 + 16'(k), 0, t0 + 3 + 4 * k);
        expect_ack(0, 16'h0D00, 0, t0 + 19);
        expect_ack(1, 16'h5004, 0, t0 + 23);
        wait_drain(60);

        // Store with 3 stall cycles
        stall_left = 3;
        en_cycles = 0;
        wr_cycles = 0;
        wr_count = 0;
        t0 = cyc;
        d_q.push_back('{1'b1, 16'h0300, 16'hBEEF});
        expect_ack(1, 16'h5004, 0, t0 + 6);
        wait_drain(40);
        check("store_en_cycles", en_cycles, 4);
        check("store_wr_cycles", wr_cycles, 4);
        check("store_writes", wr_count, 1);
        check("store_mem_data", rd(16'h0300), 16'hBEEF);

        // Flush in WAIT_I, done 2 cycles later
        cfg_delay = 3;
        t0 = cyc;
        i_q.push_back(16'h0040);
        wait_to(t0 + 2);
        check("flush_in_wait", {bus.busy, bus.mem_en}, 32'd2);
        i_q.delete();
        bus.i_flush = 1'b1;
        next_cycle();
        bus.i_flush = 1'b0;
        wait_to(t0 + 6);
        check("flush_idle", bus.busy, 0);
        check("flush_rdata_kept", bus.i_rdata, 16'h0D00);
        cfg_delay = 1;
        t0 = cyc;
        i_q.push_back(16'h0050);
        expect_ack(0, 16'hABCD, 0, t0 + 3);
        wait_drain(40);

        // Timeout: no done -> ack+err 16 cycles after entering WAIT_I
        no_done = 1;
        t0 = cyc;
        i_q.push_back(16'h0060);
        expect_ack(0, 16'hABCD, 1, t0 + 18);
        wait_drain(40);
        check("timeout_idle", bus.busy, 0);

        // Reset mid-WAIT_D
        t0 = cyc;
        d_q.push_back('{1'b0, 16'h0070, 16'h0000});
        wait_to(t0 + 5);
        check("pre_reset_busy", bus.busy, 1);
        d_q.delete();
        rst = 1'b0;
        #1;
        check("midrst_busy", bus.busy, 0);
        check("midrst_strobes", {bus.mem_en, bus.mem_wr, bus.i_ack, bus.d_ack, bus.err}, 0);
        check("midrst_data", {bus.i_rdata, bus.d_rdata}, 0);
        check("midrst_mem_regs", {bus.mem_addr, bus.mem_wdata}, 0);
        repeat (2) next_cycle();
        rst = 1'b1;
        no_done = 0;
        repeat (2) next_cycle();

        // Recovery fetch after reset
        t0 = cyc;
        i_q.push_back(16'h0010);
        expect_ack(0, 16'h0800, 0, t0 + 3);
        wait_drain(40);
        check("sb_empty_at_end", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
